// File: rtl/mdc_job_scheduler.sv
// Front-end controller for the matrix-determinant datapath: captures a 4x4 matrix
// stream, decodes the size mode and issues the 2x2-minor jobs over valid/ready.
module mdc_job_scheduler #(
  parameter int DW      = 11,
  parameter int MW      = 5,
  parameter int TIMEOUT = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic [MW-1:0] in_mode,
  output logic          job_valid,
  input  logic          job_ready,
  output logic [1:0]    job_r0,
  output logic [1:0]    job_r1,
  output logic [1:0]    job_c0,
  output logic [1:0]    job_c1,
  output logic [DW-1:0] job_a,
  output logic [DW-1:0] job_b,
  output logic [DW-1:0] job_c,
  output logic [DW-1:0] job_d,
  output logic [1:0]    job_mode,
  output logic          job_last,
  input  logic          dp_done,
  output logic          out_valid,
  output logic          out_err,
  output logic          busy
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [3:0]          r_beat;
  logic [15:0][DW-1:0] r_mat;
  logic [15:0][DW-1:0] w_mat_now;
  logic [1:0]          r_mode;       // 1=2x2, 2=3x3, 3=4x4, 0=bad mode
  logic [3:0]          r_job_idx;
  logic [TW-1:0]       r_wait_cnt;
  logic                r_err;

  logic                r_job_valid;
  logic                r_job_last;
  logic [1:0]          r_job_mode;
  logic [1:0]          r_job_r0, r_job_r1, r_job_c0, r_job_c1;
  logic [DW-1:0]       r_job_a, r_job_b, r_job_c, r_job_d;

  logic                w_cap;
  logic                w_job_load;
  logic                w_job_clear;
  logic [3:0]          w_job_k;
  logic                w_err_set;
  logic                w_err_val;
  logic [7:0]          w_coords;
  logic [1:0]          w_r0, w_r1, w_c0, w_c1;

  function automatic logic [1:0] mode_decode(input logic [MW-1:0] md);
    case (md)
      MW'(5'b00100): return 2'd1;
      MW'(5'b00110): return 2'd2;
      MW'(5'b10110): return 2'd3;
      default:       return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] last_idx(input logic [1:0] m);
    case (m)
      2'd1:    return 4'd8;
      2'd2:    return 4'd11;
      default: return 4'd5;
    endcase
  endfunction

  // Returns {r0, r1, c0, c1} for job k of mode m.
  function automatic logic [7:0] job_coords(input logic [1:0] m, input logic [3:0] k);
    logic [1:0] r, c, c0, c1;
    logic [2:0] kc;
    r  = 2'(k / 4'd3);
    c  = 2'(k % 4'd3);
    kc = 3'((m == 2'd2 && k >= 4'd6) ? k - 4'd6 : k);
    case (kc)
      3'd0:    {c0, c1} = {2'd0, 2'd1};
      3'd1:    {c0, c1} = {2'd0, 2'd2};
      3'd2:    {c0, c1} = {2'd0, 2'd3};
      3'd3:    {c0, c1} = {2'd1, 2'd2};
      3'd4:    {c0, c1} = {2'd1, 2'd3};
      default: {c0, c1} = {2'd2, 2'd3};
    endcase
    if (m == 2'd1) return {r, r + 2'd1, c, c + 2'd1};
    r = (m == 2'd2 && k < 4'd6) ? 2'd1 : 2'd2;
    return {r, r + 2'd1, c0, c1};
  endfunction

  always_comb begin
    w_state_next = r_state;
    w_cap        = 1'b0;
    w_job_load   = 1'b0;
    w_job_clear  = 1'b0;
    w_job_k      = 4'd0;
    w_err_set    = 1'b0;
    w_err_val    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_cap        = 1'b1;
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!in_valid) begin
          w_state_next = S_IDLE;
        end else begin
          w_cap = 1'b1;
          if (r_beat == 4'd15) begin
            if (r_mode != 2'd0) begin
              w_state_next = S_ISSUE;
              w_job_load   = 1'b1;
            end else begin
              w_state_next = S_DONE;
              w_err_set    = 1'b1;
              w_err_val    = 1'b1;
            end
          end
        end
      end
      S_ISSUE: begin
        if (r_job_valid && job_ready) begin
          if (r_job_last) begin
            w_state_next = S_WAIT;
            w_job_clear  = 1'b1;
          end else begin
            w_job_load = 1'b1;
            w_job_k    = r_job_idx + 4'd1;
          end
        end
      end
      S_WAIT: begin
        // A completion arriving on the timeout cycle still counts as success.
        if (dp_done) begin
          w_state_next = S_DONE;
          w_err_set    = 1'b1;
        end else if (r_wait_cnt == TW'(TIMEOUT - 1)) begin
          w_state_next = S_DONE;
          w_err_set    = 1'b1;
          w_err_val    = 1'b1;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Job 0 is loaded on the same edge as beat 15, so forward the incoming word.
  always_comb begin
    w_mat_now = r_mat;
    if (w_cap) w_mat_now[r_beat] = in_data;
  end

  assign w_coords = job_coords(r_mode, w_job_k);
  assign w_r0 = w_coords[7:6];
  assign w_r1 = w_coords[5:4];
  assign w_c0 = w_coords[3:2];
  assign w_c1 = w_coords[1:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat      <= 4'd0;
      r_mat       <= '0;
      r_mode      <= 2'd0;
      r_wait_cnt  <= '0;
      r_err       <= 1'b0;
      r_job_idx   <= 4'd0;
      r_job_valid <= 1'b0;
      r_job_last  <= 1'b0;
      r_job_mode  <= 2'd0;
      r_job_r0    <= 2'd0;
      r_job_r1    <= 2'd0;
      r_job_c0    <= 2'd0;
      r_job_c1    <= 2'd0;
      r_job_a     <= '0;
      r_job_b     <= '0;
      r_job_c     <= '0;
      r_job_d     <= '0;
    end else begin
      r_beat <= w_cap ? r_beat + 4'd1 : 4'd0;
      if (w_cap) r_mat[r_beat] <= in_data;
      if (r_state == S_IDLE && in_valid) r_mode <= mode_decode(in_mode);
      r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + TW'(1) : '0;
      if (w_err_set) r_err <= w_err_val;
      if (w_job_load) begin
        r_job_valid <= 1'b1;
        r_job_idx   <= w_job_k;
        r_job_last  <= (w_job_k == last_idx(r_mode));
        r_job_mode  <= r_mode;
        r_job_r0    <= w_r0;
        r_job_r1    <= w_r1;
        r_job_c0    <= w_c0;
        r_job_c1    <= w_c1;
        r_job_a     <= w_mat_now[{w_r0, w_c0}];
        r_job_b     <= w_mat_now[{w_r0, w_c1}];
        r_job_c     <= w_mat_now[{w_r1, w_c0}];
        r_job_d     <= w_mat_now[{w_r1, w_c1}];
      end else if (w_job_clear) begin
        r_job_valid <= 1'b0;
        r_job_idx   <= 4'd0;
        r_job_last  <= 1'b0;
        r_job_mode  <= 2'd0;
        r_job_r0    <= 2'd0;
        r_job_r1    <= 2'd0;
        r_job_c0    <= 2'd0;
        r_job_c1    <= 2'd0;
        r_job_a     <= '0;
        r_job_b     <= '0;
        r_job_c     <= '0;
        r_job_d     <= '0;
      end
    end
  end

  assign job_valid = r_job_valid;
  assign job_last  = r_job_last;
  assign job_mode  = r_job_mode;
  assign job_r0    = r_job_r0;
  assign job_r1    = r_job_r1;
  assign job_c0    = r_job_c0;
  assign job_c1    = r_job_c1;
  assign job_a     = r_job_a;
  assign job_b     = r_job_b;
  assign job_c     = r_job_c;
  assign job_d     = r_job_d;
  assign out_valid = (r_state == S_DONE);
  assign out_err   = (r_state == S_DONE) && r_err;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mdc_job_scheduler.sv
// Randomized bench for mdc_job_scheduler: a queue-based job model checked every cycle,
// plus directed frames whose job values and latencies are pinned to hand-computed numbers.
`timescale 1ns/1ps
module tb_mdc_job_scheduler;
  localparam int DW = 11;
  localparam int MW = 5;
  localparam int TIMEOUT = 1000;
  localparam int P_IDLE = 0, P_LOAD = 1, P_ISSUE = 2, P_WAIT = 3, P_DONE = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [MW-1:0] in_mode = '0;
  logic          job_ready = 1'b0;
  logic          dp_done = 1'b0;
  logic          job_valid, job_last, out_valid, out_err, busy;
  logic [1:0]    job_r0, job_r1, job_c0, job_c1, job_mode;
  logic [DW-1:0] job_a, job_b, job_c, job_d;

  always #5 clk = ~clk;

  mdc_job_scheduler #(.DW(DW), .MW(MW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_mode(in_mode),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_r0(job_r0), .job_r1(job_r1), .job_c0(job_c0), .job_c1(job_c1),
    .job_a(job_a), .job_b(job_b), .job_c(job_c), .job_d(job_d),
    .job_mode(job_mode), .job_last(job_last), .dp_done(dp_done),
    .out_valid(out_valid), .out_err(out_err), .busy(busy)
  );

  typedef struct packed {
    logic [1:0] r0, r1, c0, c1;
    logic [DW-1:0] a, b, c, d;
  } job_t;

  // Reference model state
  int            m_phase = P_IDLE;
  int            m_beat = 0;
  int            cyc = 0;
  int            m_wait_start = 0;
  bit            m_started = 1'b0;
  bit            m_err = 1'b0;
  logic [1:0]    m_jm = 2'd0;
  logic [DW-1:0] m_mat [16];
  logic [MW-1:0] m_mode_in = '0;
  job_t          m_jobs[$];

  int   n_vec = 0;
  int   n_err = 0;
  job_t hs_log[$];
  bit   hs_last[$];
  logic [1:0] hs_mode[$];
  int   ov_count = 0;
  int   ov_cyc = 0;
  bit   last_err = 1'b0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic job_t mk_job(input int r0, input int r1, input int c0, input int c1);
    job_t j;
    j.r0 = 2'(r0); j.r1 = 2'(r1); j.c0 = 2'(c0); j.c1 = 2'(c1);
    j.a = m_mat[r0*4+c0]; j.b = m_mat[r0*4+c1];
    j.c = m_mat[r1*4+c0]; j.d = m_mat[r1*4+c1];
    return j;
  endfunction

  function automatic void build_jobs();
    int rp_lo;
    m_jobs.delete();
    m_jm  = 2'd0;
    rp_lo = 3;
    if (m_mode_in == 5'b00100) begin
      m_jm = 2'd1;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) m_jobs.push_back(mk_job(r, r + 1, c, c + 1));
    end else if (m_mode_in == 5'b00110) begin
      m_jm = 2'd2; rp_lo = 1;
    end else if (m_mode_in == 5'b10110) begin
      m_jm = 2'd3; rp_lo = 2;
    end
    for (int r = rp_lo; r <= 2; r++)
      for (int c0 = 0; c0 < 3; c0++)
        for (int c1 = c0 + 1; c1 < 4; c1++) m_jobs.push_back(mk_job(r, r + 1, c0, c1));
  endfunction

  always @(posedge clk) begin
    int c_now;
    c_now = cyc;
    cyc = cyc + 1;
    m_started = 1'b1;
    if (rst) begin
      m_phase = P_IDLE; m_beat = 0; m_err = 1'b0; m_jobs.delete();
    end else begin
      case (m_phase)
        P_IDLE: if (in_valid) begin
          m_mat[0] = in_data; m_mode_in = in_mode; m_beat = 1; m_phase = P_LOAD;
        end
        P_LOAD: if (!in_valid) m_phase = P_IDLE;
        else begin
          m_mat[m_beat] = in_data;
          m_beat++;
          if (m_beat == 16) begin
            build_jobs();
            if (m_jobs.size() == 0) begin m_err = 1'b1; m_phase = P_DONE; end
            else m_phase = P_ISSUE;
          end
        end
        P_ISSUE: if (job_ready) begin
          void'(m_jobs.pop_front());
          if (m_jobs.size() == 0) begin m_phase = P_WAIT; m_wait_start = cyc; end
        end
        P_WAIT: begin
          if (dp_done) begin m_err = 1'b0; m_phase = P_DONE; end
          else if (c_now - m_wait_start == TIMEOUT - 1) begin m_err = 1'b1; m_phase = P_DONE; end
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    job_t ej, aj;
    bit iss;
    if (m_started) begin
      iss = (m_phase == P_ISSUE) && (m_jobs.size() > 0);
      ej  = '0;
      if (iss) ej = m_jobs[0];
      aj = {job_r0, job_r1, job_c0, job_c1, job_a, job_b, job_c, job_d};
      chk("job_valid", 64'(job_valid), 64'(iss));
      chk("job_coords", 64'({aj.r0, aj.r1, aj.c0, aj.c1}), 64'({ej.r0, ej.r1, ej.c0, ej.c1}));
      chk("job_data", 64'({aj.a, aj.b, aj.c, aj.d}), 64'({ej.a, ej.b, ej.c, ej.d}));
      chk("job_last", 64'(job_last), 64'(iss && m_jobs.size() == 1));
      chk("job_mode", 64'(job_mode), 64'(iss ? m_jm : 2'd0));
      chk("out_valid", 64'(out_valid), 64'(m_phase == P_DONE));
      chk("out_err", 64'(out_err), 64'(m_phase == P_DONE && m_err));
      chk("busy", 64'(busy), 64'(m_phase != P_IDLE));
      if (job_valid && job_ready) begin
        hs_log.push_back(aj); hs_last.push_back(job_last); hs_mode.push_back(job_mode);
      end
      if (out_valid) begin
        ov_count++; ov_cyc = cyc; last_err = out_err;
        $display("frame %0d complete: err=%0d jobs=%0d cycle=%0d", ov_count, out_err, hs_log.size(), cyc);
      end
    end
  end

  function automatic job_t hs_at(input int i);
    if (i < hs_log.size()) return hs_log[i];
    return '0;
  endfunction
  function automatic logic [63:0] jdat(input job_t j);
    return 64'({j.a, j.b, j.c, j.d});
  endfunction
  function automatic logic [63:0] jcrd(input job_t j);
    return 64'({j.r0, j.r1, j.c0, j.c1});
  endfunction
  function automatic logic [63:0] d4(input int a, input int b, input int c, input int d);
    return 64'({DW'(a), DW'(b), DW'(c), DW'(d)});
  endfunction
  function automatic logic [63:0] c4(input int a, input int b, input int c, input int d);
    return 64'({2'(a), 2'(b), 2'(c), 2'(d)});
  endfunction
  function automatic int last_pos();
    for (int i = 0; i < hs_last.size(); i++) if (hs_last[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_logs();
    hs_log.delete(); hs_last.delete(); hs_mode.delete();
  endtask

  task automatic send_frame(input logic [MW-1:0] mode, input bit rnd, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      in_valid = 1'b1;
      in_data  = rnd ? DW'($urandom) : DW'(i);
      in_mode  = (i == 0) ? mode : MW'($urandom);
      tick();
    end
    in_valid = 1'b0;
    in_data  = DW'($urandom);
    in_mode  = MW'($urandom);
  endtask

  task automatic wait_phase(input int ph, input int budget);
    int n = 0;
    while (m_phase != ph && n < budget) begin tick(); n++; end
    chk("phase_reached", 64'(m_phase), 64'(ph));
  endtask

  task automatic run_until_idle(input int budget, input int rdy_pct, input bit allow_done,
                                input bit noise, input bit allow_rst);
    int n = 0;
    while (m_phase != P_IDLE && n < budget) begin
      job_ready = ($urandom_range(99) < rdy_pct);
      dp_done   = allow_done && ($urandom_range(7) == 0);
      rst       = allow_rst && ($urandom_range(149) == 0);
      if (noise && (m_phase == P_ISSUE || m_phase == P_WAIT)) begin
        in_valid = 1'($urandom_range(1));
        in_data  = DW'($urandom);
        in_mode  = MW'($urandom);
      end else in_valid = 1'b0;
      tick();
      n++;
    end
    job_ready = 1'b0; dp_done = 1'b0; rst = 1'b0; in_valid = 1'b0;
    chk("idle_within_budget", 64'(m_phase), 64'(P_IDLE));
  endtask

  initial begin
    int n, ov0, tb15, cnt2;
    logic [MW-1:0] md;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_outputs", 64'({job_valid, job_last, job_mode, out_valid, out_err, busy, job_a}), 64'd0);

    // 2x2, ramp matrix, ready held high, completion three WAIT cycles in
    reset_logs(); ov0 = ov_count; job_ready = 1'b1;
    send_frame(5'b00100, 1'b0, 16);
    wait_phase(P_WAIT, 40);
    tick(); tick(); dp_done = 1'b1; tick(); dp_done = 1'b0;
    wait_phase(P_IDLE, 10);
    job_ready = 1'b0;
    chk("t1_njobs", 64'(hs_log.size()), 64'd9);
    chk("t1_first", jdat(hs_at(0)), d4(0, 1, 4, 5));
    chk("t1_last_data", jdat(hs_at(8)), d4(10, 11, 14, 15));
    chk("t1_last_pos", 64'(last_pos()), 64'(8));
    chk("t1_outs", 64'(ov_count - ov0), 64'd1);
    chk("t1_err", 64'(last_err), 64'd0);

    // 4x4 with a four-cycle stall on job 2
    reset_logs(); job_ready = 1'b1;
    send_frame(5'b10110, 1'b0, 16);
    n = 0;
    while (hs_log.size() < 2 && n < 50) begin tick(); n++; end
    job_ready = 1'b0;
    repeat (4) tick();
    job_ready = 1'b1;
    wait_phase(P_WAIT, 40);
    dp_done = 1'b1; tick(); dp_done = 1'b0; job_ready = 1'b0;
    wait_phase(P_IDLE, 10);
    chk("t2_njobs", 64'(hs_log.size()), 64'd6);
    chk("t2_first", jdat(hs_at(0)), d4(8, 9, 12, 13));
    chk("t2_job2", jcrd(hs_at(2)), c4(2, 3, 0, 3));
    chk("t2_job2_data", jdat(hs_at(2)), d4(8, 11, 12, 15));
    chk("t2_last", jdat(hs_at(5)), d4(10, 11, 14, 15));

    // 3x3 with random back-pressure and input noise while busy
    reset_logs();
    send_frame(5'b00110, 1'b0, 16);
    run_until_idle(300, 70, 1'b1, 1'b1, 1'b0);
    cnt2 = 0;
    foreach (hs_mode[i]) if (hs_mode[i] == 2'd2) cnt2++;
    chk("t3_njobs", 64'(hs_log.size()), 64'd12);
    chk("t3_job6", jcrd(hs_at(6)), c4(2, 3, 0, 1));
    chk("t3_job6_data", jdat(hs_at(6)), d4(8, 9, 12, 13));
    chk("t3_mode_all2", 64'(cnt2), 64'd12);

    // Bad mode, then an aborted frame followed by a clean one
    reset_logs();
    send_frame(5'b11111, 1'b0, 16);
    tb15 = cyc - 1;
    run_until_idle(10, 100, 1'b1, 1'b0, 1'b0);
    chk("t4_njobs", 64'(hs_log.size()), 64'd0);
    chk("t4_latency", 64'(ov_cyc - tb15), 64'd1);
    chk("t4_err", 64'(last_err), 64'd1);
    reset_logs(); ov0 = ov_count;
    send_frame(5'b00100, 1'b1, 8);
    repeat (10) tick();
    chk("t4_abort_busy", 64'(busy), 64'd0);
    chk("t4_abort_outs", 64'(ov_count - ov0), 64'd0);
    send_frame(5'b00100, 1'b1, 16);
    run_until_idle(200, 100, 1'b1, 1'b0, 1'b0);
    chk("t4_after_abort_jobs", 64'(hs_log.size()), 64'd9);
    chk("t4_after_abort_outs", 64'(ov_count - ov0), 64'd1);

    // Timeout, then reset during ISSUE
    reset_logs(); job_ready = 1'b1;
    send_frame(5'b00100, 1'b0, 16);
    run_until_idle(1200, 100, 1'b0, 1'b0, 1'b0);
    chk("t5_timeout_latency", 64'(ov_cyc - m_wait_start), 64'(TIMEOUT));
    chk("t5_timeout_err", 64'(last_err), 64'd1);
    job_ready = 1'b0;
    send_frame(5'b10110, 1'b1, 16);
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_rst_outputs", 64'({job_valid, busy, out_valid, job_a}), 64'd0);
    tick();

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(3))
        0:       md = 5'b00100;
        1:       md = 5'b00110;
        2:       md = 5'b10110;
        default: md = MW'($urandom);
      endcase
      repeat ($urandom_range(3)) tick();
      reset_logs();
      send_frame(md, 1'b1, ($urandom_range(7) == 0) ? int'($urandom_range(1, 15)) : 16);
      run_until_idle(500, int'($urandom_range(30, 100)), 1'b1, 1'b1, 1'b1);
    end

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
